// File: rtl/lin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lin_pkg
// Description : Shared definitions for the LIN command parser and the
//               per-channel lin_ctrl instances: command type codes, error
//               codes, packet word counts and the parser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lin_pkg;

  // Header type codes (header word [31:24])
  localparam logic [7:0] CMD_CFG = 8'h01;
  localparam logic [7:0] CMD_FRM = 8'h02;

  // Error codes reported on cmd_err_code
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TYPE = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CHAN = 2'd3;

  // Packet lengths in 32-bit words, header included
  localparam int CFG_WORDS = 2;
  localparam int FRM_WORDS = 4;

  typedef enum logic [2:0] {
    ST_HDR      = 3'd0,
    ST_CFG_W1   = 3'd1,
    ST_FRM_W1   = 3'd2,
    ST_FRM_DH   = 3'd3,
    ST_FRM_DL   = 3'd4,
    ST_WAIT_RDY = 3'd5,
    ST_ISSUE    = 3'd6,
    ST_DRAIN    = 3'd7
  } state_e;

endpackage : lin_pkg
`default_nettype wire

// File: rtl/lin_cmd_fields.sv
`default_nettype none
// ============================================================================
// Module      : lin_cmd_fields
// Description : Combinational word-to-field slicer. All command field bit
//               positions live here and nowhere else.
// Ports       : hdr_i         header word (type, channel)
//               w1_i          payload word 1 (config fields / frame id+op)
//               dh_i, dl_i    frame data high / low words
//               *_o           sliced fields
// Revision    : 1.0 - initial release
// ============================================================================
module lin_cmd_fields
  import lin_pkg::*;
(
  input  logic [31:0] hdr_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] dh_i,
  input  logic [31:0] dl_i,
  output logic [7:0]  type_o,
  output logic [7:0]  channel_o,
  output logic [23:0] baudrate_o,
  output logic        mode_o,
  output logic        parity_type_o,
  output logic        int_termin_o,
  output logic [5:0]  frame_id_o,
  output logic [1:0]  op_type_o,
  output logic [63:0] frame_data_o
);

  assign type_o        = hdr_i[31:24];
  assign channel_o     = hdr_i[23:16];

  assign baudrate_o    = w1_i[23:0];
  assign mode_o        = w1_i[24];
  assign parity_type_o = w1_i[25];
  assign int_termin_o  = w1_i[26];

  assign frame_id_o    = w1_i[5:0];
  assign op_type_o     = w1_i[9:8];
  assign frame_data_o  = {dh_i, dl_i};

  // Reserved bits carry no meaning in either packet format.
  logic w_unused_bits;
  assign w_unused_bits = ^{hdr_i[15:0], w1_i[31:27]};

endmodule : lin_cmd_fields
`default_nettype wire

// File: rtl/lin_cmd_parse.sv
`default_nettype none
// ============================================================================
// Module      : lin_cmd_parse
// Description : Downlink command parser. Decodes AXI-Stream command packets
//               into configuration or frame requests and drives the shared
//               lin_config_* / lin_frame_* bus with a one-cycle strobe once
//               the addressed channel reports lin_ready. Malformed packets
//               are drained and flagged on cmd_err / cmd_err_code.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               s_axis_*                 command stream slave
//               lin_ready                per-channel ready flags
//               lin_config_*, lin_mode,  configuration command outputs
//               lin_baudrate, ...
//               lin_frame_*, lin_op_type frame request outputs
//               cmd_err, cmd_err_code    error strobe and sticky code
// Revision    : 1.0 - initial release
// ============================================================================
module lin_cmd_parse
  import lin_pkg::*;
#(
  parameter int          CHANNEL_NUM = 4,
  parameter int unsigned RDY_TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  input  logic [CHANNEL_NUM-1:0] lin_ready,
  output logic                   lin_config_vld,
  output logic [7:0]             lin_config_channel,
  output logic                   lin_mode,
  output logic [23:0]            lin_baudrate,
  output logic                   lin_parity_type,
  output logic                   lin_int_termin,
  output logic                   lin_frame_vld,
  output logic [1:0]             lin_op_type,
  output logic [5:0]             lin_frame_id,
  output logic [63:0]            lin_frame_data,
  output logic                   cmd_err,
  output logic [1:0]             cmd_err_code
);

  localparam logic [8:0]  c_CH_LIMIT = 9'(CHANNEL_NUM);
  localparam logic [31:0] c_TIMEOUT  = 32'(RDY_TIMEOUT);
  localparam bit          c_TO_EN    = (RDY_TIMEOUT != 0);
  localparam logic [2:0]  c_CFG_LAST = 3'(CFG_WORDS - 1);
  localparam logic [2:0]  c_FRM_LAST = 3'(FRM_WORDS - 1);
  localparam logic [23:0] c_BAUD_RST = 24'd50;

  state_e      state_q, state_d;
  logic        tready_q, tready_d;
  logic [31:0] w1_q, w1_d, dh_q, dh_d, dl_q, dl_d;
  logic [7:0]  ch_q, ch_d;
  logic        is_frm_q, is_frm_d;
  logic [2:0]  wcnt_q, wcnt_d;      // index of the next payload word
  logic [31:0] tocnt_q, tocnt_d;

  logic        cfg_vld_q, cfg_vld_d, frm_vld_q, frm_vld_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  out_ch_q, out_ch_d;
  logic [23:0] baud_q, baud_d;
  logic        mode_q, mode_d, par_q, par_d, term_q, term_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  id_q, id_d;
  logic [63:0] data_q, data_d;

  logic [7:0]  w_hdr_type, w_hdr_channel;
  logic [23:0] w_baud;
  logic        w_mode, w_par, w_term;
  logic [5:0]  w_id;
  logic [1:0]  w_op;
  logic [63:0] w_data;

  // Header is sliced from the live stream; payload fields from the
  // captured words so the output registers load them at issue time.
  lin_cmd_fields u_fields (
    .hdr_i         (s_axis_tdata),
    .w1_i          (w1_q),
    .dh_i          (dh_q),
    .dl_i          (dl_q),
    .type_o        (w_hdr_type),
    .channel_o     (w_hdr_channel),
    .baudrate_o    (w_baud),
    .mode_o        (w_mode),
    .parity_type_o (w_par),
    .int_termin_o  (w_term),
    .frame_id_o    (w_id),
    .op_type_o     (w_op),
    .frame_data_o  (w_data)
  );

  logic        w_acc, w_exp_last, w_rdy;
  logic [31:0] w_tocnt_inc;

  assign w_acc       = s_axis_tvalid & tready_q;
  assign w_exp_last  = is_frm_q ? (wcnt_q == c_FRM_LAST) : (wcnt_q == c_CFG_LAST);
  assign w_tocnt_inc = (tocnt_q == 32'hFFFF_FFFF) ? tocnt_q : tocnt_q + 32'd1;

  // Ready of the addressed channel; the channel was range-checked in HDR.
  always_comb begin
    w_rdy = 1'b0;
    for (int n = 0; n < CHANNEL_NUM; n++) begin
      if (ch_q == 8'(n)) w_rdy = lin_ready[n];
    end
  end

  always_comb begin
    state_d    = state_q;
    w1_d       = w1_q;
    dh_d       = dh_q;
    dl_d       = dl_q;
    ch_d       = ch_q;
    is_frm_d   = is_frm_q;
    wcnt_d     = wcnt_q;
    tocnt_d    = tocnt_q;
    cfg_vld_d  = 1'b0;
    frm_vld_d  = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    out_ch_d   = out_ch_q;
    baud_d     = baud_q;
    mode_d     = mode_q;
    par_d      = par_q;
    term_d     = term_q;
    op_d       = op_q;
    id_d       = id_q;
    data_d     = data_q;

    case (state_q)
      ST_HDR: begin
        if (w_acc) begin
          ch_d     = w_hdr_channel;
          is_frm_d = (w_hdr_type == CMD_FRM);
          wcnt_d   = 3'd1;
          // A rejected header that already ends its packet has nothing
          // left to drain, so it returns straight to HDR.
          if (w_hdr_type != CMD_CFG && w_hdr_type != CMD_FRM) begin
            err_d      = 1'b1;
            err_code_d = ERR_TYPE;
            state_d    = s_axis_tlast ? ST_HDR : ST_DRAIN;
          end else if ({1'b0, w_hdr_channel} >= c_CH_LIMIT) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHAN;
            state_d    = s_axis_tlast ? ST_HDR : ST_DRAIN;
          end else if (s_axis_tlast) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_HDR;
          end else begin
            state_d = (w_hdr_type == CMD_FRM) ? ST_FRM_W1 : ST_CFG_W1;
          end
        end
      end

      ST_CFG_W1, ST_FRM_W1, ST_FRM_DH, ST_FRM_DL: begin
        if (w_acc) begin
          wcnt_d = wcnt_q + 3'd1;
          if (state_q == ST_CFG_W1 || state_q == ST_FRM_W1) w1_d = s_axis_tdata;
          else if (state_q == ST_FRM_DH)                     dh_d = s_axis_tdata;
          else                                               dl_d = s_axis_tdata;

          if (s_axis_tlast) begin
            if (w_exp_last) begin
              state_d = ST_WAIT_RDY;
              tocnt_d = 32'd0;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_LEN;
              state_d    = ST_HDR;
            end
          end else if (w_exp_last) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_DRAIN;
          end else begin
            state_d = (state_q == ST_FRM_W1) ? ST_FRM_DH : ST_FRM_DL;
          end
        end
      end

      ST_WAIT_RDY: begin
        if (w_rdy) begin
          // Strobe and fields are registered together on entry to ISSUE.
          state_d  = ST_ISSUE;
          out_ch_d = ch_q;
          if (is_frm_q) begin
            frm_vld_d = 1'b1;
            op_d      = w_op;
            id_d      = w_id;
            data_d    = w_data;
          end else begin
            cfg_vld_d = 1'b1;
            baud_d    = w_baud;
            mode_d    = w_mode;
            par_d     = w_par;
            term_d    = w_term;
          end
        end else if (c_TO_EN && w_tocnt_inc >= c_TIMEOUT) begin
          err_d      = 1'b1;
          err_code_d = ERR_CHAN;
          state_d    = ST_HDR;
        end else begin
          tocnt_d = w_tocnt_inc;
        end
      end

      ST_ISSUE: state_d = ST_HDR;

      ST_DRAIN: begin
        if (w_acc && s_axis_tlast) state_d = ST_HDR;
      end

      default: state_d = ST_HDR;
    endcase

    tready_d = !(state_d == ST_WAIT_RDY || state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      tready_q   <= 1'b0;
      w1_q       <= '0;
      dh_q       <= '0;
      dl_q       <= '0;
      ch_q       <= '0;
      is_frm_q   <= 1'b0;
      wcnt_q     <= '0;
      tocnt_q    <= '0;
      cfg_vld_q  <= 1'b0;
      frm_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      out_ch_q   <= '0;
      baud_q     <= c_BAUD_RST;
      mode_q     <= 1'b0;
      par_q      <= 1'b0;
      term_q     <= 1'b0;
      op_q       <= '0;
      id_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      w1_q       <= w1_d;
      dh_q       <= dh_d;
      dl_q       <= dl_d;
      ch_q       <= ch_d;
      is_frm_q   <= is_frm_d;
      wcnt_q     <= wcnt_d;
      tocnt_q    <= tocnt_d;
      cfg_vld_q  <= cfg_vld_d;
      frm_vld_q  <= frm_vld_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      out_ch_q   <= out_ch_d;
      baud_q     <= baud_d;
      mode_q     <= mode_d;
      par_q      <= par_d;
      term_q     <= term_d;
      op_q       <= op_d;
      id_q       <= id_d;
      data_q     <= data_d;
    end
  end

  assign s_axis_tready      = tready_q;
  assign lin_config_vld     = cfg_vld_q;
  assign lin_frame_vld      = frm_vld_q;
  assign lin_config_channel = out_ch_q;
  assign lin_baudrate       = baud_q;
  assign lin_mode           = mode_q;
  assign lin_parity_type    = par_q;
  assign lin_int_termin     = term_q;
  assign lin_op_type        = op_q;
  assign lin_frame_id       = id_q;
  assign lin_frame_data     = data_q;
  assign cmd_err            = err_q;
  assign cmd_err_code       = err_code_q;

endmodule : lin_cmd_parse
`default_nettype wire

// File: tb/tb_lin_cmd_parse.sv
`default_nettype none
// ============================================================================
// Module      : tb_lin_cmd_parse
// Description : Self-checking bench for lin_cmd_parse. Expected bus events
//               are derived from packet contents by a reference model and
//               queued; a monitor compares every strobe / error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lin_cmd_parse;

  localparam int CH_N = 4;
  localparam int TO   = 30;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tlast = 1'b0;
  logic            s_axis_tready;
  logic [CH_N-1:0] lin_ready = '1;
  logic            lin_config_vld, lin_frame_vld, cmd_err;
  logic [7:0]      lin_config_channel;
  logic            lin_mode, lin_parity_type, lin_int_termin;
  logic [23:0]     lin_baudrate;
  logic [1:0]      lin_op_type, cmd_err_code;
  logic [5:0]      lin_frame_id;
  logic [63:0]     lin_frame_data;

  lin_cmd_parse #(.CHANNEL_NUM(CH_N), .RDY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .lin_ready(lin_ready),
    .lin_config_vld(lin_config_vld), .lin_config_channel(lin_config_channel),
    .lin_mode(lin_mode), .lin_baudrate(lin_baudrate),
    .lin_parity_type(lin_parity_type), .lin_int_termin(lin_int_termin),
    .lin_frame_vld(lin_frame_vld), .lin_op_type(lin_op_type),
    .lin_frame_id(lin_frame_id), .lin_frame_data(lin_frame_data),
    .cmd_err(cmd_err), .cmd_err_code(cmd_err_code)
  );

  always #5 clk = ~clk;

  // kind: 1 = config strobe, 2 = frame strobe, 3 = error pulse
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  code;
    logic [7:0]  ch;
    logic [23:0] baud;
    logic        mode, par, term;
    logic [1:0]  op;
    logic [5:0]  id;
    logic [63:0] data;
  } ev_t;

  ev_t         sb[$];
  ev_t         m_st;          // model of the output bus contents
  logic [31:0] pkt[$];
  int          checks = 0, passes = 0;
  int          cyc = 0, t_acc = 0, err_cyc = 0;
  bit          rand_gaps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] outs();
    return {15'b0, s_axis_tready, lin_config_vld, lin_frame_vld, cmd_err, cmd_err_code,
            lin_config_channel, lin_baudrate, lin_mode, lin_parity_type, lin_int_termin,
            lin_op_type, lin_frame_id, lin_frame_data};
  endfunction

  localparam logic [127:0] c_RST_OUTS = {15'b0, 4'b0000, 2'd0, 8'd0, 24'd50, 3'b000, 2'd0, 6'd0, 64'd0};

  task automatic model_reset();
    m_st = '{kind: 2'd0, code: 2'd0, ch: 8'd0, baud: 24'd50, mode: 1'b0, par: 1'b0,
             term: 1'b0, op: 2'd0, id: 6'd0, data: 64'd0};
  endtask

  task automatic expect_ev(input logic [1:0] kind);
    ev_t e;
    e = m_st;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Outcome of a packet from its words alone, with the addressed channel
  // assumed ready before the timeout.
  task automatic model_pkt();
    logic [31:0] h, w1;
    logic [7:0]  typ, ch;
    int          n, len;
    h   = pkt[0];
    typ = h[31:24];
    ch  = h[23:16];
    n   = pkt.size();
    len = (typ == 8'h01) ? 2 : 4;
    if (typ != 8'h01 && typ != 8'h02) begin
      m_st.code = 2'd1; expect_ev(2'd3);
    end else if (int'(ch) >= CH_N) begin
      m_st.code = 2'd3; expect_ev(2'd3);
    end else if (n != len) begin
      m_st.code = 2'd2; expect_ev(2'd3);
    end else begin
      w1 = pkt[1];
      m_st.ch = ch;
      if (typ == 8'h01) begin
        m_st.baud = w1[23:0];
        m_st.mode = w1[24];
        m_st.par  = w1[25];
        m_st.term = w1[26];
        expect_ev(2'd1);
      end else begin
        m_st.id   = w1[5:0];
        m_st.op   = w1[9:8];
        m_st.data = {pkt[2], pkt[3]};
        expect_ev(2'd2);
      end
    end
  endtask

  task automatic sb_check(input logic [1:0] kind);
    ev_t act, exp;
    act = {kind, cmd_err_code, lin_config_channel, lin_baudrate, lin_mode, lin_parity_type,
           lin_int_termin, lin_op_type, lin_frame_id, lin_frame_data};
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_unexpected: got %h expected no event", act);
    end else begin
      exp = sb.pop_front();
      if (act === exp) passes++;
      else $display("FAIL sb_event: got %h expected %h", act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_err) begin
        sb_check(2'd3);
        err_cyc = cyc;
      end
      if (lin_config_vld || lin_frame_vld) sb_check(lin_frame_vld ? 2'd2 : 2'd1);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [31:0] w, input logic last);
    bit ok;
    if (rand_gaps && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    s_axis_tdata  = w;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    ok = 0;
    for (int b = 0; b < 300; b++) begin
      @(negedge clk);
      if (s_axis_tready) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL push_word: tready 0 expected 1 within 300 cycles");
      $display("%0d/%0d checks passed", passes, checks + 1);
      $fatal(1, "stream stalled");
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    t_acc = cyc;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) push_word(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic wait_drain(input string name);
    for (int b = 0; b < 400 && sb.size() != 0; b++) @(negedge clk);
    check(name, 128'(sb.size()), 128'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic gen_random();
    int          sel, n, len;
    logic [7:0]  typ, ch;
    sel = $urandom_range(0, 9);
    pkt.delete();
    typ = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
    ch  = 8'($urandom_range(0, CH_N - 1));
    len = (typ == 8'h01) ? 2 : 4;
    n   = len;
    if (sel <= 3) begin
      typ = 8'h01; n = 2;
    end else if (sel <= 6) begin
      typ = 8'h02; n = 4;
    end else if (sel == 7) begin
      typ = 8'($urandom);
      if (typ == 8'h01 || typ == 8'h02) typ = 8'hA5;
      n = $urandom_range(1, 4);
    end else if (sel == 8) begin
      ch = 8'($urandom_range(CH_N, 255));
      n  = $urandom_range(1, 4);
    end else begin
      do n = $urandom_range(1, 6); while (n == len);
    end
    pkt.push_back({typ, ch, 16'($urandom)});
    for (int i = 1; i < n; i++) pkt.push_back($urandom);
  endtask

  initial begin
    int bad;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_values", outs(), c_RST_OUTS);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_reset", 128'(s_axis_tready), 128'd1);
    @(posedge clk); #1;

    // Config on ch 0 with exact strobe latency and tready sequence
    pkt = '{32'h0100_0000, 32'h0300_0032};
    model_pkt();
    send_pkt();
    @(negedge clk);
    check("lat_n1", {126'd0, s_axis_tready, lin_config_vld}, 128'b00);
    @(negedge clk);
    check("lat_n2", {126'd0, s_axis_tready, lin_config_vld}, 128'b01);
    @(negedge clk);
    check("lat_n3", {126'd0, s_axis_tready, lin_config_vld}, 128'b10);
    wait_drain("drain_cfg0");

    // Frame on ch 2 held off by lin_ready[2]
    lin_ready = 4'b1011;
    pkt = '{32'h0202_0000, 32'h0000_013C, 32'h1122_3344, 32'h5566_7788};
    model_pkt();
    send_pkt();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_axis_tready || lin_config_vld || lin_frame_vld) bad++;
    end
    check("rdy_low_hold", 128'(bad), 128'd0);
    @(posedge clk); #1 lin_ready = 4'hF;
    wait_drain("drain_frm2");

    // Bad type, drained, then a good packet
    pkt = '{32'h0701_0000, 32'hDEAD_BEEF, 32'h0102_0304};
    model_pkt(); send_pkt();
    pkt = '{32'h0103_1234, 32'h0412_3456};
    model_pkt(); send_pkt();
    wait_drain("drain_badtype");

    // Frame with early tlast, frame missing tlast, channel out of range
    pkt = '{32'h0201_0000, 32'h0000_0011, 32'h0000_0022};
    model_pkt(); send_pkt();
    pkt = '{32'h0201_0000, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h44, 32'h55};
    model_pkt(); send_pkt();
    pkt = '{32'h0105_0000, 32'h0000_0099};
    model_pkt(); send_pkt();
    pkt = '{32'h0201_0000, 32'h0000_0215, 32'hCAFE_F00D, 32'h0BAD_CAFE};
    model_pkt(); send_pkt();
    wait_drain("drain_len_chan");

    // Ready timeout: no strobe, code 3 after TO cycles in WAIT_RDY
    lin_ready = 4'b0111;
    pkt = '{32'h0103_0000, 32'h0000_1000};
    m_st.code = 2'd3;
    expect_ev(2'd3);
    send_pkt();
    wait_drain("drain_timeout");
    check("timeout_latency", 128'(err_cyc - t_acc), 128'(TO));
    lin_ready = 4'hF;

    // Randomized packets
    rand_gaps = 1;
    for (int k = 0; k < 40; k++) begin
      gen_random();
      model_pkt();
      send_pkt();
    end
    rand_gaps = 0;
    wait_drain("drain_random");

    // A known frame so the reset check sees non-reset field values
    pkt = '{32'h0201_0000, 32'h0000_0127, 32'hFFFF_0000, 32'h0000_FFFF};
    model_pkt(); send_pkt();
    wait_drain("drain_pre_reset");

    // Reset between FRM_DH and FRM_DL
    push_word(32'h0201_0000, 1'b0);
    push_word(32'h0000_0101, 1'b0);
    push_word(32'h1234_5678, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_packet", outs(), c_RST_OUTS);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("tready_after_reset2", 128'(s_axis_tready), 128'd1);
    @(posedge clk); #1;
    pkt = '{32'h0102_0000, 32'h0500_0960};
    model_pkt(); send_pkt();
    wait_drain("drain_post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_lin_cmd_parse
`default_nettype wire
